// File: rtl/rob_commit.sv
// Reorder buffer with in-order retire and failed-branch squash walk.
// Define ROB_PERF_CNT_EN to add retire/flush performance counters.
module rob_commit #(
  parameter int ROB_IDX_W = 5,
  parameter int PR_W      = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   alloc_valid,
  output logic                   alloc_ready,
  input  logic [1:0]             alloc_dest_mask,
  input  logic [7:0]             alloc_arch_regs,
  input  logic [2*PR_W-1:0]      alloc_phys_regs,
  input  logic [2*PR_W-1:0]      alloc_old_phys_regs,
  output logic [ROB_IDX_W-1:0]   alloc_rob_entry,
  input  logic [3*ROB_IDX_W-1:0] ROB_entries_in,
  input  logic                   complete_arith_valid,
  input  logic                   complete_mem_valid,
  input  logic                   complete_term_valid,
  output logic                   complete_term_ready,
  input  logic                   complete_term_failed,
  input  logic [15:0]            term_address,
  output logic                   retire_valid,
  output logic [1:0]             retire_dest_mask,
  output logic [7:0]             retire_arch_regs,
  output logic [2*PR_W-1:0]      retire_phys_regs,
  output logic                   free_valid,
  output logic [1:0]             free_mask,
  output logic [2*PR_W-1:0]      free_phys_regs,
  output logic                   flush_valid,
  output logic [15:0]            flush_addr
`ifdef ROB_PERF_CNT_EN
  ,
  output logic [31:0]            perf_retired,
  output logic [15:0]            perf_flushes
`endif
);

  localparam int DEPTH = 1 << ROB_IDX_W;
  localparam int CNT_W = ROB_IDX_W + 1;

  typedef enum logic {
    S_RUN,
    S_DRAIN
  } state_t;

  state_t state_q, state_d;

  logic [ROB_IDX_W-1:0] head_q, head_d;
  logic [ROB_IDX_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0]     count_q, count_d;

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] done_q, done_d;
  logic [DEPTH-1:0] failed_q, failed_d;

  logic [1:0]        mask_q [DEPTH];
  logic [1:0]        mask_d [DEPTH];
  logic [7:0]        arch_q [DEPTH];
  logic [7:0]        arch_d [DEPTH];
  logic [2*PR_W-1:0] phys_q [DEPTH];
  logic [2*PR_W-1:0] phys_d [DEPTH];
  logic [2*PR_W-1:0] old_q  [DEPTH];
  logic [2*PR_W-1:0] old_d  [DEPTH];
  logic [15:0]       addr_q [DEPTH];
  logic [15:0]       addr_d [DEPTH];

  logic [ROB_IDX_W-1:0] idx_a, idx_m, idx_t;
  logic run, ret, flush, full, pop;
  logic drain_walk, alloc_fire;
  logic arith_hit, mem_hit, term_hit;

  assign idx_a = ROB_entries_in[3*ROB_IDX_W-1 -: ROB_IDX_W];
  assign idx_m = ROB_entries_in[2*ROB_IDX_W-1 -: ROB_IDX_W];
  assign idx_t = ROB_entries_in[ROB_IDX_W-1:0];

  assign run        = (state_q == S_RUN);
  assign ret        = run & valid_q[head_q] & done_q[head_q];
  assign flush      = ret & failed_q[head_q];
  assign full       = (count_q == CNT_W'(DEPTH));
  assign drain_walk = (state_q == S_DRAIN) & (count_q != '0);
  assign pop        = ret | drain_walk;
  assign alloc_fire = alloc_valid & alloc_ready;
  assign arith_hit  = run & complete_arith_valid & valid_q[idx_a];
  assign mem_hit    = run & complete_mem_valid & valid_q[idx_m];
  assign term_hit   = run & complete_term_valid & valid_q[idx_t];

  // Handshake and retire/free/flush outputs, all decoded from the head entry
  always_comb begin
    alloc_ready         = run & ~full & ~flush;
    alloc_rob_entry     = tail_q;
    complete_term_ready = run;
    retire_valid        = ret;
    retire_dest_mask    = '0;
    retire_arch_regs    = '0;
    retire_phys_regs    = '0;
    free_valid          = pop & (mask_q[head_q] != 2'b00);
    free_mask           = '0;
    free_phys_regs      = '0;
    flush_valid         = flush;
    flush_addr          = '0;
    if (ret) begin
      retire_dest_mask = mask_q[head_q];
      retire_arch_regs = arch_q[head_q];
      retire_phys_regs = phys_q[head_q];
    end
    if (free_valid) begin
      free_mask      = mask_q[head_q];
      free_phys_regs = ret ? old_q[head_q] : phys_q[head_q];
    end
    if (flush) begin
      flush_addr = addr_q[head_q];
    end
  end

  // Control next state: completions, head pop, tail push, count, FSM
  always_comb begin
    state_d  = state_q;
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    valid_d  = valid_q;
    done_d   = done_q;
    failed_d = failed_q;
    if (arith_hit) done_d[idx_a] = 1'b1;
    if (mem_hit) done_d[idx_m] = 1'b1;
    if (term_hit) begin
      done_d[idx_t]   = 1'b1;
      failed_d[idx_t] = complete_term_failed;
    end
    if (pop) begin
      valid_d[head_q]  = 1'b0;
      done_d[head_q]   = 1'b0;
      failed_d[head_q] = 1'b0;
      head_d           = head_q + ROB_IDX_W'(1);
    end
    if (alloc_fire) begin
      valid_d[tail_q]  = 1'b1;
      done_d[tail_q]   = 1'b0;
      failed_d[tail_q] = 1'b0;
      tail_d           = tail_q + ROB_IDX_W'(1);
    end
    unique case (1'b1)
      alloc_fire & ~pop: count_d = count_q + CNT_W'(1);
      pop & ~alloc_fire: count_d = count_q - CNT_W'(1);
      default: ;
    endcase
    unique case (state_q)
      S_RUN: begin
        if (flush && count_q != CNT_W'(1)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (count_q <= CNT_W'(1)) state_d = S_RUN;
      end
      default: state_d = S_RUN;
    endcase
  end

  // Entry payload next state: dispatch fields and term redirect address
  always_comb begin
    mask_d = mask_q;
    arch_d = arch_q;
    phys_d = phys_q;
    old_d  = old_q;
    addr_d = addr_q;
    if (alloc_fire) begin
      mask_d[tail_q] = alloc_dest_mask;
      arch_d[tail_q] = alloc_arch_regs;
      phys_d[tail_q] = alloc_phys_regs;
      old_d[tail_q]  = alloc_old_phys_regs;
    end
    if (term_hit) begin
      addr_d[idx_t] = term_address;
    end
  end

  // Control registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_RUN;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      valid_q  <= '0;
      done_q   <= '0;
      failed_q <= '0;
    end else begin
      state_q  <= state_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
      failed_q <= failed_d;
    end
  end

  // Payload storage is qualified by valid bits and needs no reset
  always_ff @(posedge clk) begin
    mask_q <= mask_d;
    arch_q <= arch_d;
    phys_q <= phys_d;
    old_q  <= old_d;
    addr_q <= addr_d;
  end

`ifdef ROB_PERF_CNT_EN
  logic [31:0] perf_retired_q, perf_retired_d;
  logic [15:0] perf_flushes_q, perf_flushes_d;

  // Free-running event counters that wrap silently
  always_comb begin
    perf_retired_d = perf_retired_q + 32'(ret);
    perf_flushes_d = perf_flushes_q + 16'(flush);
  end

  // Counter registers cleared by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_retired_q <= '0;
      perf_flushes_q <= '0;
    end else begin
      perf_retired_q <= perf_retired_d;
      perf_flushes_q <= perf_flushes_d;
    end
  end

  assign perf_retired = perf_retired_q;
  assign perf_flushes = perf_flushes_q;
`endif

endmodule

// File: tb/tb_rob_commit.sv
// Directed bench for rob_commit.
// Checks retire order, full, squash drain and reset.
module tb_rob_commit;
  logic        clk;
  logic        rst;
  logic        alloc_valid;
  logic        alloc_ready;
  logic [1:0]  alloc_dest_mask;
  logic [7:0]  alloc_arch_regs;
  logic [9:0]  alloc_phys_regs;
  logic [9:0]  alloc_old_phys_regs;
  logic [4:0]  alloc_rob_entry;
  logic [14:0] ROB_entries_in;
  logic        complete_arith_valid;
  logic        complete_mem_valid;
  logic        complete_term_valid;
  logic        complete_term_ready;
  logic        complete_term_failed;
  logic [15:0] term_address;
  logic        retire_valid;
  logic [1:0]  retire_dest_mask;
  logic [7:0]  retire_arch_regs;
  logic [9:0]  retire_phys_regs;
  logic        free_valid;
  logic [1:0]  free_mask;
  logic [9:0]  free_phys_regs;
  logic        flush_valid;
  logic [15:0] flush_addr;
`ifdef ROB_PERF_CNT_EN
  logic [31:0] perf_retired;
  logic [15:0] perf_flushes;
`endif

  int n_cmp = 0;
  int n_fail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  rob_commit dut (
    .clk                 (clk),
    .rst                 (rst),
    .alloc_valid         (alloc_valid),
    .alloc_ready         (alloc_ready),
    .alloc_dest_mask     (alloc_dest_mask),
    .alloc_arch_regs     (alloc_arch_regs),
    .alloc_phys_regs     (alloc_phys_regs),
    .alloc_old_phys_regs (alloc_old_phys_regs),
    .alloc_rob_entry     (alloc_rob_entry),
    .ROB_entries_in      (ROB_entries_in),
    .complete_arith_valid(complete_arith_valid),
    .complete_mem_valid  (complete_mem_valid),
    .complete_term_valid (complete_term_valid),
    .complete_term_ready (complete_term_ready),
    .complete_term_failed(complete_term_failed),
    .term_address        (term_address),
    .retire_valid        (retire_valid),
    .retire_dest_mask    (retire_dest_mask),
    .retire_arch_regs    (retire_arch_regs),
    .retire_phys_regs    (retire_phys_regs),
    .free_valid          (free_valid),
    .free_mask           (free_mask),
    .free_phys_regs      (free_phys_regs),
    .flush_valid         (flush_valid),
    .flush_addr          (flush_addr)
`ifdef ROB_PERF_CNT_EN
    ,
    .perf_retired        (perf_retired),
    .perf_flushes        (perf_flushes)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  function automatic logic [14:0] ents(input logic [4:0] a,
                                       input logic [4:0] m,
                                       input logic [4:0] t);
    return {a, m, t};
  endfunction

  task automatic idle();
    alloc_valid          = 1'b0;
    complete_arith_valid = 1'b0;
    complete_mem_valid   = 1'b0;
    complete_term_valid  = 1'b0;
    complete_term_failed = 1'b0;
    term_address         = 16'h0;
    ROB_entries_in       = 15'h0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic alloc1(input logic [4:0] exp_idx, input logic [1:0] m,
                        input logic [7:0] a, input logic [9:0] p,
                        input logic [9:0] o);
    alloc_valid         = 1'b1;
    alloc_dest_mask     = m;
    alloc_arch_regs     = a;
    alloc_phys_regs     = p;
    alloc_old_phys_regs = o;
    sample();
    chk("alloc_ready", 32'(alloc_ready), 1);
    chk("alloc_idx", 32'(alloc_rob_entry), 32'(exp_idx));
    tick();
    alloc_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    alloc_dest_mask = '0;
    alloc_arch_regs = '0;
    alloc_phys_regs = '0;
    alloc_old_phys_regs = '0;
    do_reset();

    // reset state
    sample();
    chk("rst_alloc_ready", 32'(alloc_ready), 1);
    chk("rst_term_ready", 32'(complete_term_ready), 1);
    chk("rst_retire", 32'(retire_valid), 0);
    chk("rst_free", 32'(free_valid), 0);
    chk("rst_flush", 32'(flush_valid), 0);
    chk("rst_idx", 32'(alloc_rob_entry), 0);
    chk("rst_flush_addr", 32'(flush_addr), 0);
    chk("rst_free_phys", 32'(free_phys_regs), 0);
    tick();

    // out-of-order completion, in-order retire
    alloc1(5'd0, 2'b01, 8'h21, {5'd10, 5'd11}, {5'd1, 5'd2});
    alloc1(5'd1, 2'b11, 8'h43, {5'd12, 5'd13}, {5'd3, 5'd4});
    alloc1(5'd2, 2'b00, 8'h00, {5'd14, 5'd15}, {5'd5, 5'd6});
    complete_arith_valid = 1'b1;
    ROB_entries_in = ents(5'd2, 5'd0, 5'd0);
    sample();
    chk("t1_noret_a", 32'(retire_valid), 0);
    tick();
    idle();
    complete_mem_valid = 1'b1;
    ROB_entries_in = ents(5'd0, 5'd0, 5'd0);
    sample();
    chk("t1_noret_b", 32'(retire_valid), 0);
    tick();
    idle();
    complete_term_valid = 1'b1;
    ROB_entries_in = ents(5'd0, 5'd0, 5'd1);
    sample();
    chk("t1_r0_valid", 32'(retire_valid), 1);
    chk("t1_r0_mask", 32'(retire_dest_mask), 1);
    chk("t1_r0_arch", 32'(retire_arch_regs), 'h21);
    chk("t1_r0_phys", 32'(retire_phys_regs), 32'({5'd10, 5'd11}));
    chk("t1_r0_free", 32'(free_valid), 1);
    chk("t1_r0_fmask", 32'(free_mask), 1);
    chk("t1_r0_fphys", 32'(free_phys_regs), 32'({5'd1, 5'd2}));
    chk("t1_r0_flush", 32'(flush_valid), 0);
    tick();
    idle();
    sample();
    chk("t1_r1_valid", 32'(retire_valid), 1);
    chk("t1_r1_arch", 32'(retire_arch_regs), 'h43);
    chk("t1_r1_fmask", 32'(free_mask), 3);
    chk("t1_r1_fphys", 32'(free_phys_regs), 32'({5'd3, 5'd4}));
    tick();
    sample();
    chk("t1_r2_valid", 32'(retire_valid), 1);
    chk("t1_r2_phys", 32'(retire_phys_regs), 32'({5'd14, 5'd15}));
    chk("t1_r2_free", 32'(free_valid), 0);
    tick();
    sample();
    chk("t1_empty", 32'(retire_valid), 0);
    chk("t1_tail", 32'(alloc_rob_entry), 3);
    tick();

    // fill to 32, retire one with a blocked alloc, then wrap
    do_reset();
    for (int i = 0; i < 32; i++) begin
      alloc1(5'(i), 2'b01, 8'(i), 10'(i), 10'(i + 100));
    end
    sample();
    chk("t2_full_ready", 32'(alloc_ready), 0);
    chk("t2_full_tail", 32'(alloc_rob_entry), 0);
    tick();
    complete_arith_valid = 1'b1;
    ROB_entries_in = ents(5'd0, 5'd0, 5'd0);
    alloc_valid = 1'b1;
    alloc_dest_mask = 2'b01;
    alloc_arch_regs = 8'h77;
    alloc_phys_regs = 10'd7;
    alloc_old_phys_regs = 10'd9;
    sample();
    chk("t2_a_ready", 32'(alloc_ready), 0);
    chk("t2_a_ret", 32'(retire_valid), 0);
    tick();
    complete_arith_valid = 1'b0;
    sample();
    chk("t2_b_ret", 32'(retire_valid), 1);
    chk("t2_b_fphys", 32'(free_phys_regs), 100);
    chk("t2_b_ready", 32'(alloc_ready), 0);
    tick();
    sample();
    chk("t2_c_ready", 32'(alloc_ready), 1);
    chk("t2_c_tail", 32'(alloc_rob_entry), 0);
    tick();
    alloc_valid = 1'b0;
    sample();
    chk("t2_d_ready", 32'(alloc_ready), 0);
    chk("t2_d_tail", 32'(alloc_rob_entry), 1);
    tick();

    // failed term squashes younger entries
    do_reset();
    alloc1(5'd0, 2'b01, 8'h10, {5'd1, 5'd2}, {5'd3, 5'd4});
    alloc1(5'd1, 2'b01, 8'h11, {5'd5, 5'd6}, {5'd7, 5'd8});
    alloc1(5'd2, 2'b11, 8'h12, {5'd20, 5'd21}, {5'd9, 5'd9});
    alloc1(5'd3, 2'b00, 8'h13, {5'd22, 5'd23}, {5'd9, 5'd9});
    alloc1(5'd4, 2'b10, 8'h14, {5'd24, 5'd25}, {5'd9, 5'd9});
    complete_arith_valid = 1'b1;
    complete_term_valid = 1'b1;
    complete_term_failed = 1'b1;
    term_address = 16'hC0DE;
    ROB_entries_in = ents(5'd0, 5'd0, 5'd1);
    sample();
    chk("t3_term_ready", 32'(complete_term_ready), 1);
    tick();
    idle();
    sample();
    chk("t3_r0_ret", 32'(retire_valid), 1);
    chk("t3_r0_arch", 32'(retire_arch_regs), 'h10);
    chk("t3_r0_flush", 32'(flush_valid), 0);
    chk("t3_r0_fphys", 32'(free_phys_regs), 32'({5'd3, 5'd4}));
    tick();
    alloc_valid = 1'b1;
    sample();
    chk("t3_r1_ret", 32'(retire_valid), 1);
    chk("t3_r1_flush", 32'(flush_valid), 1);
    chk("t3_r1_faddr", 32'(flush_addr), 'hC0DE);
    chk("t3_r1_ready", 32'(alloc_ready), 0);
    chk("t3_r1_fphys", 32'(free_phys_regs), 32'({5'd7, 5'd8}));
    tick();
    alloc_valid = 1'b0;
    complete_arith_valid = 1'b1;
    complete_term_valid = 1'b1;
    ROB_entries_in = ents(5'd2, 5'd0, 5'd3);
    sample();
    chk("t3_d1_ret", 32'(retire_valid), 0);
    chk("t3_d1_flush", 32'(flush_valid), 0);
    chk("t3_d1_tready", 32'(complete_term_ready), 0);
    chk("t3_d1_aready", 32'(alloc_ready), 0);
    chk("t3_d1_free", 32'(free_valid), 1);
    chk("t3_d1_fmask", 32'(free_mask), 3);
    chk("t3_d1_fphys", 32'(free_phys_regs), 32'({5'd20, 5'd21}));
    tick();
    idle();
    sample();
    chk("t3_d2_free", 32'(free_valid), 0);
    chk("t3_d2_tready", 32'(complete_term_ready), 0);
    tick();
    sample();
    chk("t3_d3_free", 32'(free_valid), 1);
    chk("t3_d3_fmask", 32'(free_mask), 2);
    chk("t3_d3_fphys", 32'(free_phys_regs), 32'({5'd24, 5'd25}));
    chk("t3_d3_tready", 32'(complete_term_ready), 0);
    tick();
    sample();
    chk("t3_run_tready", 32'(complete_term_ready), 1);
    chk("t3_run_aready", 32'(alloc_ready), 1);
    chk("t3_run_tail", 32'(alloc_rob_entry), 5);
    chk("t3_run_free", 32'(free_valid), 0);
    chk("t3_run_ret", 32'(retire_valid), 0);
    tick();
    alloc1(5'd5, 2'b01, 8'h15, 10'd1, 10'd2);
    complete_mem_valid = 1'b1;
    ROB_entries_in = ents(5'd0, 5'd5, 5'd0);
    tick();
    idle();
    sample();
    chk("t3_head5_ret", 32'(retire_valid), 1);
    chk("t3_head5_arch", 32'(retire_arch_regs), 'h15);
    tick();

    // completions to a non-live entry are ignored
    do_reset();
    alloc1(5'd0, 2'b01, 8'hA0, 10'd0, 10'd0);
    alloc1(5'd1, 2'b01, 8'hA1, 10'd0, 10'd0);
    alloc1(5'd2, 2'b01, 8'hA2, 10'd0, 10'd0);
    complete_arith_valid = 1'b1;
    complete_mem_valid = 1'b1;
    complete_term_valid = 1'b1;
    complete_term_failed = 1'b1;
    term_address = 16'hDEAD;
    ROB_entries_in = ents(5'd7, 5'd7, 5'd7);
    tick();
    idle();
    sample();
    chk("t4_noret", 32'(retire_valid), 0);
    tick();
    alloc1(5'd3, 2'b01, 8'hA3, 10'd0, 10'd0);
    alloc1(5'd4, 2'b01, 8'hA4, 10'd0, 10'd0);
    alloc1(5'd5, 2'b01, 8'hA5, 10'd0, 10'd0);
    alloc1(5'd6, 2'b01, 8'hA6, 10'd0, 10'd0);
    alloc1(5'd7, 2'b01, 8'hA7, 10'd0, 10'd0);
    complete_arith_valid = 1'b1;
    complete_mem_valid = 1'b1;
    complete_term_valid = 1'b1;
    ROB_entries_in = ents(5'd0, 5'd1, 5'd2);
    tick();
    ROB_entries_in = ents(5'd3, 5'd4, 5'd5);
    sample();
    chk("t4_r0_arch", 32'(retire_arch_regs), 'hA0);
    tick();
    idle();
    complete_arith_valid = 1'b1;
    ROB_entries_in = ents(5'd6, 5'd0, 5'd0);
    sample();
    chk("t4_r1_arch", 32'(retire_arch_regs), 'hA1);
    tick();
    idle();
    for (int k = 2; k < 7; k++) begin
      sample();
      chk("t4_rk_ret", 32'(retire_valid), 1);
      chk("t4_rk_arch", 32'(retire_arch_regs), 32'(8'hA0 + k));
      chk("t4_rk_flush", 32'(flush_valid), 0);
      tick();
    end
    sample();
    chk("t4_e7_notdone", 32'(retire_valid), 0);
    tick();

    // reset while draining
    do_reset();
    alloc1(5'd0, 2'b01, 8'hB0, {5'd1, 5'd1}, {5'd2, 5'd2});
    alloc1(5'd1, 2'b11, 8'hB1, {5'd16, 5'd17}, {5'd2, 5'd2});
    alloc1(5'd2, 2'b01, 8'hB2, {5'd18, 5'd19}, {5'd2, 5'd2});
    alloc1(5'd3, 2'b01, 8'hB3, {5'd26, 5'd27}, {5'd2, 5'd2});
    complete_term_valid = 1'b1;
    complete_term_failed = 1'b1;
    term_address = 16'h1234;
    ROB_entries_in = ents(5'd0, 5'd0, 5'd0);
    tick();
    idle();
    sample();
    chk("t5_flush", 32'(flush_valid), 1);
    chk("t5_faddr", 32'(flush_addr), 'h1234);
    tick();
    sample();
    chk("t5_d1_fphys", 32'(free_phys_regs), 32'({5'd16, 5'd17}));
    tick();
    rst = 1'b1;
    sample();
    chk("t5_d2_fphys", 32'(free_phys_regs), 32'({5'd18, 5'd19}));
    tick();
    rst = 1'b0;
    sample();
    chk("t5_rst_free", 32'(free_valid), 0);
    chk("t5_rst_aready", 32'(alloc_ready), 1);
    chk("t5_rst_tready", 32'(complete_term_ready), 1);
    chk("t5_rst_tail", 32'(alloc_rob_entry), 0);
    chk("t5_rst_ret", 32'(retire_valid), 0);
    tick();

    // five retires, last one a failed term with nothing younger
    alloc1(5'd0, 2'b01, 8'hC0, 10'd0, 10'd0);
    alloc1(5'd1, 2'b01, 8'hC1, 10'd0, 10'd0);
    alloc1(5'd2, 2'b01, 8'hC2, 10'd0, 10'd0);
    alloc1(5'd3, 2'b01, 8'hC3, 10'd0, 10'd0);
    alloc1(5'd4, 2'b01, 8'hC4, 10'd0, 10'd0);
    complete_arith_valid = 1'b1;
    complete_mem_valid = 1'b1;
    complete_term_valid = 1'b1;
    ROB_entries_in = ents(5'd0, 5'd1, 5'd2);
    tick();
    idle();
    complete_arith_valid = 1'b1;
    complete_term_valid = 1'b1;
    complete_term_failed = 1'b1;
    term_address = 16'hBEEF;
    ROB_entries_in = ents(5'd3, 5'd0, 5'd4);
    sample();
    chk("t6_r0_arch", 32'(retire_arch_regs), 'hC0);
    tick();
    idle();
    for (int k = 1; k < 4; k++) begin
      sample();
      chk("t6_rk_arch", 32'(retire_arch_regs), 32'(8'hC0 + k));
      chk("t6_rk_flush", 32'(flush_valid), 0);
      tick();
    end
    sample();
    chk("t6_r4_arch", 32'(retire_arch_regs), 'hC4);
    chk("t6_r4_flush", 32'(flush_valid), 1);
    chk("t6_r4_faddr", 32'(flush_addr), 'hBEEF);
    tick();
    sample();
    chk("t6_run_ret", 32'(retire_valid), 0);
    chk("t6_run_aready", 32'(alloc_ready), 1);
    chk("t6_run_tready", 32'(complete_term_ready), 1);
    chk("t6_run_free", 32'(free_valid), 0);
`ifdef ROB_PERF_CNT_EN
    chk("t6_perf_ret", perf_retired, 5);
    chk("t6_perf_flush", 32'(perf_flushes), 1);
`endif
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
